// File: rtl/cs_pkg.sv
// Shared constants and types for the CS sliding-window datapath.
package cs_pkg;

  localparam int unsigned CS_WIN = 9;
  localparam int unsigned CS_XW  = 8;
  localparam int unsigned CS_YW  = 10;

  typedef logic [CS_YW-1:0] y_t;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } col_state_e;

endpackage

// File: rtl/cs_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags and occupancy.
module cs_sync_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] level_d;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_d = level;
    if (do_push && !do_pop) begin
      level_d = level + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/cs_y_collector.sv
// Collects CS-stage Y samples after window warm-up and streams them out over valid/ready.
module cs_y_collector
  import cs_pkg::*;
#(
  parameter int unsigned DW     = CS_YW,
  parameter int unsigned WARMUP = CS_WIN - 1,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CW     = 8,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] y_in,
  input  logic          y_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          primed,
  output logic          overflow,
  output logic [CW-1:0] drop_cnt,
  output logic [LW-1:0] level
);

  localparam int unsigned WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  col_state_e     state_q;
  col_state_e     state_d;
  logic [WCW-1:0] warm_cnt_q;
  logic [WCW-1:0] warm_cnt_d;
  logic           overflow_d;
  logic [CW-1:0]  drop_cnt_d;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           drop;

  assign primed    = (state_q == RUN);
  assign out_valid = ~fifo_empty;
  assign push      = y_en & primed;
  assign pop       = out_valid & out_ready;
  assign drop      = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WARM;
      warm_cnt_q <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      overflow   <= overflow_d;
      drop_cnt   <= drop_cnt_d;
    end
  end

  // Warm-up counter freezes once the window is full; drop counter saturates.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    overflow_d = overflow;
    drop_cnt_d = drop_cnt;
    case (state_q)
      WARM: begin
        if (y_en) begin
          if (warm_cnt_q == WCW'(WARMUP - 1)) begin
            state_d = RUN;
          end else begin
            warm_cnt_d = warm_cnt_q + WCW'(1);
          end
        end
      end
      RUN: begin
        if (drop) begin
          overflow_d = 1'b1;
          if (drop_cnt != {CW{1'b1}}) begin
            drop_cnt_d = drop_cnt + CW'(1);
          end
        end
      end
      default: state_d = WARM;
    endcase
  end

  cs_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (y_in),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_cs_y_collector.sv
// Scoreboard bench for cs_y_collector: default instance plus a small CW=3/DEPTH=2 instance.
module tb_cs_y_collector;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] y_in;
  logic       y_en;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       primed;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [3:0] level;

  logic       s_reset;
  logic [9:0] s_y_in;
  logic       s_y_en;
  logic [9:0] s_out_data;
  logic       s_out_valid;
  logic       s_out_ready;
  logic       s_primed;
  logic       s_overflow;
  logic [2:0] s_drop_cnt;
  logic [1:0] s_level;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];

  cs_y_collector dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .y_en      (y_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .primed    (primed),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  cs_y_collector #(.DEPTH(2), .CW(3)) dut_s (
    .clk       (clk),
    .reset     (s_reset),
    .y_in      (s_y_in),
    .y_en      (s_y_en),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .primed    (s_primed),
    .overflow  (s_overflow),
    .drop_cnt  (s_drop_cnt),
    .level     (s_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected none", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic en, input logic [9:0] d);
    y_en = en;
    y_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_s(input logic en, input logic [9:0] d);
    s_y_en = en;
    s_y_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    y_en        = 1'b0;
    y_in        = '0;
    out_ready   = 1'b1;
    s_reset     = 1'b0;
    s_y_en      = 1'b0;
    s_y_in      = '0;
    s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_primed", 32'(primed), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    reset = 1'b1;

    // Warm-up discard then streaming with consumer always ready.
    for (int i = 1; i <= 20; i++) begin
      if (i > 8) exp_q.push_back(10'(i));
      cyc(1'b1, 10'(i));
      chk("t1_primed", 32'(primed), 32'(i >= 8));
      if (i == 9) begin
        chk("t1_lat_valid", 32'(out_valid), 32'(1));
        chk("t1_lat_data", 32'(out_data), 32'h009);
      end
      if (i > 8) chk("t1_level", 32'(level), 32'(1));
    end
    cyc(1'b0, 10'h000);
    chk("t1_drained", 32'(level), 32'(0));
    chk("t1_valid0", 32'(out_valid), 32'(0));

    // Consumer stalled: two of ten samples lost.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(10'(32'h100 + i));
      cyc(1'b1, 10'(32'h100 + i));
    end
    chk("t2_level", 32'(level), 32'(8));
    chk("t2_overflow", 32'(overflow), 32'(1));
    chk("t2_drop", 32'(drop_cnt), 32'(2));
    chk("t2_hold_data", 32'(out_data), 32'h100);
    out_ready = 1'b1;
    repeat (8) cyc(1'b0, 10'h000);
    chk("t2_level0", 32'(level), 32'(0));
    chk("t2_ovf_sticky", 32'(overflow), 32'(1));

    // Full FIFO with simultaneous push and pop never drops.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(10'(32'h200 + i));
      cyc(1'b1, 10'(32'h200 + i));
    end
    chk("t3_full", 32'(level), 32'(8));
    chk("t3_drop_pre", 32'(drop_cnt), 32'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(10'(32'h300 + i));
      cyc(1'b1, 10'(32'h300 + i));
      chk("t3_level", 32'(level), 32'(8));
      chk("t3_drop", 32'(drop_cnt), 32'(2));
    end
    repeat (8) cyc(1'b0, 10'h000);
    chk("t3_level0", 32'(level), 32'(0));
    chk("t3_queue", 32'(exp_q.size()), 32'(0));

    // Gapped y_en during warm-up.
    reset = 1'b0;
    cyc(1'b0, 10'h000);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) cyc(1'b1, 10'(32'h040 + i));
      else cyc(1'b0, 10'h3FF);
      chk("t4_primed", 32'(primed), 32'(i >= 14));
      chk("t4_level", 32'(level), 32'(0));
    end
    cyc(1'b0, 10'h3AA);
    chk("t4_no_store", 32'(level), 32'(0));
    exp_q.push_back(10'h055);
    cyc(1'b1, 10'h055);
    chk("t4_store_level", 32'(level), 32'(1));
    chk("t4_store_data", 32'(out_data), 32'h055);
    cyc(1'b0, 10'h000);
    chk("t4_level0", 32'(level), 32'(0));

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(10'(32'h0C0 + i));
      cyc(1'b1, 10'(32'h0C0 + i));
    end
    out_ready = 1'b1;
    repeat (3) cyc(1'b0, 10'h000);
    out_ready = 1'b0;
    chk("t5_level5", 32'(level), 32'(5));
    chk("t5_ovf", 32'(overflow), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_level", 32'(level), 32'(0));
    chk("t5_rst_valid", 32'(out_valid), 32'(0));
    chk("t5_rst_data", 32'(out_data), 32'(0));
    chk("t5_rst_ovf", 32'(overflow), 32'(0));
    chk("t5_rst_drop", 32'(drop_cnt), 32'(0));
    chk("t5_rst_primed", 32'(primed), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i >= 8) exp_q.push_back(10'(32'h0A1 + i));
      cyc(1'b1, 10'(32'h0A1 + i));
      chk("t5_primed", 32'(primed), 32'(i >= 7));
    end
    cyc(1'b0, 10'h000);
    chk("t5_level0", 32'(level), 32'(0));

    // Drop counter saturation on the CW=3, DEPTH=2 instance.
    s_reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc_s(1'b1, 10'(i));
    chk("t6_primed", 32'(s_primed), 32'(1));
    cyc_s(1'b1, 10'h011);
    cyc_s(1'b1, 10'h022);
    chk("t6_level", 32'(s_level), 32'(2));
    chk("t6_no_ovf", 32'(s_overflow), 32'(0));
    for (int k = 1; k <= 10; k++) begin
      cyc_s(1'b1, 10'(32'h3C0 + k));
      chk("t6_drop", 32'(s_drop_cnt), (k < 7) ? 32'(k) : 32'(7));
      chk("t6_ovf", 32'(s_overflow), 32'(1));
    end
    s_y_en      = 1'b0;
    s_out_ready = 1'b1;
    chk("t6_head0", 32'(s_out_data), 32'h011);
    @(posedge clk);
    #1;
    chk("t6_head1", 32'(s_out_data), 32'h022);
    @(posedge clk);
    #1;
    chk("t6_level0", 32'(s_level), 32'(0));
    chk("t6_drop_hold", 32'(s_drop_cnt), 32'(7));

    chk("final_queue", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
